// File: rtl/tcam_match_sequencer_if.sv
// Handshake bundle between a TCAM search front end and the multi-match sequencer.
// out_count exists only when MATCH_COUNT_EN is defined.
interface tcam_match_sequencer_if #(
    parameter int K = 256
);
    localparam int AW = $clog2(K);

    logic          in_valid;
    logic          in_ready;
    logic [0:K-1]  ma;
    logic          first_only;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          out_miss;
`ifdef MATCH_COUNT_EN
    logic [AW:0]   out_count;
`endif

    // master drives searches and consumes beats; slave is the sequencer
    modport master (
        output in_valid, ma, first_only, flush, out_ready,
        input  in_ready, out_valid, out_addr, out_last, out_miss
`ifdef MATCH_COUNT_EN
        , input out_count
`endif
    );

    modport slave (
        input  in_valid, ma, first_only, flush, out_ready,
        output in_ready, out_valid, out_addr, out_last, out_miss
`ifdef MATCH_COUNT_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/tcam_match_sequencer.sv
// Walks every set bit of a captured TCAM match vector in ascending index order.
// Optional MATCH_COUNT_EN adds out_count, the popcount of the captured vector.
module tcam_match_sequencer #(
    parameter int K = 256
) (
    input logic                   clk,
    input logic                   rst,
    tcam_match_sequencer_if.slave bus
);
    localparam int AW = $clog2(K);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state;
    logic [0:K-1]  pending;
    logic [0:K-1]  rest;
    logic          fo_q;
    logic [AW-1:0] enc;
    logic          emit;
    logic          last;
    logic          fire;

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        enc = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (pending[i]) enc = AW'(i);
        end
    end

    // x & (x-1) is zero exactly when at most one bit of x is set
    assign rest = pending & (pending - K'(1));
    assign emit = (state == EMIT) && !rst;
    assign last = emit && ((rest == '0) || fo_q);
    assign fire = emit && bus.out_ready;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = emit;
    assign bus.out_addr  = emit ? enc : '0;
    assign bus.out_last  = last;
    assign bus.out_miss  = emit && (pending == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            fo_q    <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending <= bus.ma;
                        fo_q    <= bus.first_only;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (last) begin
                            pending <= '0;
                            state   <= IDLE;
                        end else begin
                            pending[enc] <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATCH_COUNT_EN
    logic [AW:0] popcnt;
    logic [AW:0] count_q;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < K; i++) begin
            popcnt = popcnt + (AW + 1)'(bus.ma[i]);
        end
    end

    // loaded only on an accepted capture so it stays constant for the whole walk
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (!bus.flush && state == IDLE && bus.in_valid) begin
            count_q <= popcnt;
        end
    end

    assign bus.out_count = count_q;
`endif
endmodule
